// File: rtl/ram_sp_param_if.sv
// Access bus of the single-port RAM: request, byte-enabled write data,
// registered read result, and the clear-engine handshake.
interface ram_sp_param_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
);
  logic                    cen;
  logic                    wen;
  logic [DATA_WIDTH/8-1:0] s_wbe;
  logic [ADDR_WIDTH-1:0]   s_addr;
  logic [DATA_WIDTH-1:0]   s_din;
  logic [DATA_WIDTH-1:0]   s_dout;
  logic                    s_valid;
  logic                    init_req;
  logic                    init_busy;

  modport master (
    output cen, wen, s_wbe, s_addr, s_din, init_req,
    input  s_dout, s_valid, init_busy
  );

  modport slave (
    input  cen, wen, s_wbe, s_addr, s_din, init_req,
    output s_dout, s_valid, init_busy
  );
endinterface

// File: rtl/ram_sp_param.sv
// Parametrised single-port RAM with registered read, byte write enables,
// selectable read-during-write output and a sweep engine that clears every word.
module ram_sp_param #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DEPTH      = 256,
  parameter int                    RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic           clk,
  input logic           rst,
  ram_sp_param_if.slave bus
);
  localparam int                    BYTES       = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] dout;
  logic                  valid;
  logic                  busy;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_range;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged;
  logic                  access;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Out-of-range addresses read as zero and never reach the array.
  always_comb begin
    in_range = ({1'b0, bus.s_addr} < DEPTH_LIMIT);
    rd_addr  = in_range ? bus.s_addr : '0;
    old_word = in_range ? mem[rd_addr] : '0;
    merged   = old_word;
    for (int i = 0; i < BYTES; i++) begin
      if (bus.s_wbe[i]) merged[8*i +: 8] = bus.s_din[8*i +: 8];
    end
    access    = (state == IDLE) && !bus.init_req && bus.cen;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = INIT_VALUE;
      end else if (access && bus.wen && in_range && (|bus.s_wbe)) begin
        mem_we    = 1'b1;
        mem_waddr = bus.s_addr;
        mem_wdata = merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
      dout  <= '0;
      valid <= 1'b0;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          dout  <= '0;
          valid <= 1'b0;
          ptr   <= ptr + 1'b1;
          if (ptr == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (bus.init_req) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
            dout  <= '0;
            valid <= 1'b0;
          end else if (bus.cen) begin
            if (bus.wen) begin
              // Output seen on a write depends on the read-during-write mode.
              if (RDW_MODE == 1) begin
                dout  <= merged;
                valid <= 1'b1;
              end else if (RDW_MODE == 2) begin
                dout  <= old_word;
                valid <= 1'b1;
              end else begin
                dout  <= '0;
                valid <= 1'b0;
              end
            end else begin
              dout  <= old_word;
              valid <= 1'b1;
            end
          end else begin
            dout  <= '0;
            valid <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.s_dout    = dout;
  assign bus.s_valid   = valid;
  assign bus.init_busy = busy;
endmodule

// File: tb/tb_ram_sp_param.sv
// Bench for ram_sp_param: four instances (modes 0/1/2 at depth 256, mode 0 at
// depth 200 with a non-zero init value) share one stimulus and a memory-array model.
module tb_ram_sp_param;
  localparam logic [63:0] INIT_B = 64'hA5A5_5A5A_0F0F_F0F0;

  logic        clk = 1'b0;
  logic        rst, cen, wen, init_req;
  logic [7:0]  wbe, addr;
  logic [63:0] din;

  logic [63:0] dout_w  [4];
  logic        valid_w [4];
  logic        busy_w  [4];

  always #5 clk = ~clk;

  // Instance 3 is the short-depth variant; instances 0..2 differ only in mode.
  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int          MODE  = (g == 3) ? 0 : g;
    localparam int          DEP   = (g == 3) ? 200 : 256;
    localparam logic [63:0] INITV = (g == 3) ? INIT_B : 64'h0;

    ram_sp_param_if #(.DATA_WIDTH(64), .ADDR_WIDTH(8)) bus ();

    assign bus.cen      = cen;
    assign bus.wen      = wen;
    assign bus.s_wbe    = wbe;
    assign bus.s_addr   = addr;
    assign bus.s_din    = din;
    assign bus.init_req = init_req;
    assign dout_w[g]    = bus.s_dout;
    assign valid_w[g]   = bus.s_valid;
    assign busy_w[g]    = bus.init_busy;

    ram_sp_param #(
      .DATA_WIDTH(64), .ADDR_WIDTH(8), .DEPTH(DEP),
      .RDW_MODE(MODE), .INIT_VALUE(INITV)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  logic [63:0] mem_a [256];
  logic [63:0] mem_b [256];
  int          left_a, left_b;
  logic [63:0] exp_dout  [4];
  logic        exp_valid [4];
  logic        exp_busy  [4];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        c, w;
    logic [7:0]  be, a;
    logic [63:0] d;
    logic [63:0] exp1;
    logic        v1;
  } vec_t;

  vec_t vecs [19];

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] be);
    logic [63:0] r = old;
    for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // A sweep is modelled as a countdown plus a whole-array fill; nothing may
  // access the memory while it runs, so the fill order is unobservable.
  task automatic model_step();
    logic [63:0] old, nw;
    logic        in_b;
    if (rst) begin
      for (int g = 0; g < 4; g++) begin
        exp_dout[g] = '0; exp_valid[g] = 1'b0; exp_busy[g] = 1'b1;
      end
      for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = INIT_B; end
      left_a = 256;
      left_b = 200;
      return;
    end
    if (left_a > 0) begin
      left_a--;
      for (int g = 0; g < 3; g++) begin
        exp_dout[g] = '0; exp_valid[g] = 1'b0; exp_busy[g] = (left_a > 0);
      end
    end else if (init_req) begin
      for (int i = 0; i < 256; i++) mem_a[i] = '0;
      left_a = 256;
      for (int g = 0; g < 3; g++) begin
        exp_dout[g] = '0; exp_valid[g] = 1'b0; exp_busy[g] = 1'b1;
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        exp_dout[g] = '0; exp_valid[g] = 1'b0; exp_busy[g] = 1'b0;
      end
      if (cen) begin
        old = mem_a[addr];
        if (wen) begin
          nw = merge(old, din, wbe);
          mem_a[addr] = nw;
          exp_dout[1] = nw;  exp_valid[1] = 1'b1;
          exp_dout[2] = old; exp_valid[2] = 1'b1;
        end else begin
          for (int g = 0; g < 3; g++) begin exp_dout[g] = old; exp_valid[g] = 1'b1; end
        end
      end
    end
    if (left_b > 0) begin
      left_b--;
      exp_dout[3] = '0; exp_valid[3] = 1'b0; exp_busy[3] = (left_b > 0);
    end else if (init_req) begin
      for (int i = 0; i < 256; i++) mem_b[i] = INIT_B;
      left_b = 200;
      exp_dout[3] = '0; exp_valid[3] = 1'b0; exp_busy[3] = 1'b1;
    end else begin
      exp_dout[3] = '0; exp_valid[3] = 1'b0; exp_busy[3] = 1'b0;
      in_b = (addr < 8'd200);
      old  = in_b ? mem_b[addr] : 64'h0;
      if (cen && wen) begin
        if (in_b) mem_b[addr] = merge(old, din, wbe);
      end else if (cen) begin
        exp_dout[3] = old; exp_valid[3] = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    for (int g = 0; g < 4; g++) begin
      checks += 3;
      if (dout_w[g] !== exp_dout[g]) begin
        errors++;
        $display("[TB] FAIL %s dut%0d dout actual=%h expected=%h", tag, g, dout_w[g], exp_dout[g]);
      end
      if (valid_w[g] !== exp_valid[g]) begin
        errors++;
        $display("[TB] FAIL %s dut%0d valid actual=%b expected=%b", tag, g, valid_w[g], exp_valid[g]);
      end
      if (busy_w[g] !== exp_busy[g]) begin
        errors++;
        $display("[TB] FAIL %s dut%0d busy actual=%b expected=%b", tag, g, busy_w[g], exp_busy[g]);
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, act, req);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic w, input logic ir,
                               input logic [7:0] be, input logic [7:0] a,
                               input logic [63:0] d, input string tag);
    rst = r; cen = c; wen = w; init_req = ir; wbe = be; addr = a; din = d;
    model_step();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Counts cycles with init_busy high after reset drops, bounded at 300.
  task automatic measureSweep(input string tag);
    int cnt_a = 0, cnt_b = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy_w[0]) cnt_a++;
      if (busy_w[3]) cnt_b++;
      applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 64'h0, tag);
    end
    checkValue({tag, "_len256"}, 64'(cnt_a), 64'd256);
    checkValue({tag, "_len200"}, 64'(cnt_b), 64'd200);
  endtask

  initial begin
    vecs[0]  = '{1, 1, 8'hFF, 8'd5,   64'h1122334455667788, 64'h1122334455667788, 1};
    vecs[1]  = '{1, 1, 8'h0F, 8'd5,   64'hAAAAAAAAAAAAAAAA, 64'h11223344AAAAAAAA, 1};
    vecs[2]  = '{1, 0, 8'h00, 8'd5,   64'h0,                64'h11223344AAAAAAAA, 1};
    vecs[3]  = '{1, 1, 8'hFF, 8'd7,   64'h1,                64'h1,                1};
    vecs[4]  = '{1, 1, 8'hFF, 8'd7,   64'h2,                64'h2,                1};
    vecs[5]  = '{1, 0, 8'h00, 8'd0,   64'h0,                64'h0,                1};
    vecs[6]  = '{1, 0, 8'h00, 8'd128, 64'h0,                64'h0,                1};
    vecs[7]  = '{1, 0, 8'h00, 8'd255, 64'h0,                64'h0,                1};
    vecs[8]  = '{1, 1, 8'h00, 8'd3,   64'hFFFF,             64'h0,                1};
    vecs[9]  = '{1, 0, 8'h00, 8'd3,   64'h0,                64'h0,                1};
    vecs[10] = '{1, 1, 8'hFF, 8'd1,   64'h111,              64'h111,              1};
    vecs[11] = '{1, 1, 8'hFF, 8'd2,   64'h222,              64'h222,              1};
    vecs[12] = '{1, 0, 8'h00, 8'd1,   64'h0,                64'h111,              1};
    vecs[13] = '{1, 0, 8'h00, 8'd2,   64'h0,                64'h222,              1};
    vecs[14] = '{1, 0, 8'h00, 8'd3,   64'h0,                64'h0,                1};
    vecs[15] = '{0, 0, 8'h00, 8'd0,   64'h0,                64'h0,                0};
    vecs[16] = '{1, 1, 8'hFF, 8'd210, 64'hFF,               64'hFF,               1};
    vecs[17] = '{1, 0, 8'h00, 8'd210, 64'h0,                64'hFF,               1};
    vecs[18] = '{1, 0, 8'h00, 8'd7,   64'h0,                64'h2,                1};

    left_a = 0;
    left_b = 0;
    applyStimulus(1, 0, 0, 0, 8'h00, 8'h00, 64'h0, "reset");
    applyStimulus(1, 1, 1, 1, 8'hFF, 8'h00, 64'h5, "reset_prio");
    measureSweep("sweep");

    for (int i = 0; i < 19; i++) begin
      applyStimulus(0, vecs[i].c, vecs[i].w, 0, vecs[i].be, vecs[i].a, vecs[i].d, "vec");
      checkValue($sformatf("vec%0d_dout", i), dout_w[1], vecs[i].exp1);
      checkValue($sformatf("vec%0d_valid", i), 64'(valid_w[1]), 64'(vecs[i].v1));
      if (i == 4) begin
        checkValue("rdw_mode0", dout_w[0], 64'h0);
        checkValue("rdw_mode2", dout_w[2], 64'h1);
      end
      if (i == 17) checkValue("oor_read_d200", dout_w[3], 64'h0);
    end

    applyStimulus(0, 1, 1, 0, 8'hFF, 8'd10, 64'hDEAD, "fill10");
    applyStimulus(0, 1, 1, 1, 8'hFF, 8'd10, 64'h1234, "init_req");
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 8'h00, 8'd10, 64'h0, "mid_sweep");
    applyStimulus(1, 0, 0, 0, 8'h00, 8'h00, 64'h0, "rst_mid");
    measureSweep("resweep");
    applyStimulus(0, 1, 0, 0, 8'h00, 8'd10, 64'h0, "read10");
    checkValue("read10_d256", dout_w[0], 64'h0);
    checkValue("read10_d200", dout_w[3], INIT_B);

    for (int i = 0; i < 600; i++) begin
      logic [7:0] a;
      logic [7:0] be;
      case ($urandom_range(0, 3))
        0:       a = 8'($urandom);
        1:       a = 8'($urandom_range(196, 210));
        default: a = 8'($urandom_range(0, 15));
      endcase
      be = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0,
                    be, a, {$urandom, $urandom}, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_sp_param.md
Name: ram_sp_param

Overview:
- Parametrised single-port synchronous RAM with a registered read port, per-byte write enables, and a selectable read-during-write mode.
- Adds a built-in clear engine that sweeps every word to INIT_VALUE after reset or on request.
- Replaces fixed 64x256 scratch memories in the factorial datapath; the controller polls init_busy before issuing accesses.

Parameters:
- DATA_WIDTH, 64, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width.
- DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
- RDW_MODE, 0, read-during-write output: 0 = s_dout driven 0; 1 = write-first (new merged word); 2 = read-first (old word).
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every word by the clear engine.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cen  in  1  chip enable; access request.
- wen  in  1  1 = write, 0 = read; sampled only when cen=1.
- s_wbe  in  DATA_WIDTH/8  byte write enables; bit i covers bits [8i+7:8i].
- s_addr  in  ADDR_WIDTH  word address.
- s_din  in  DATA_WIDTH  write data.
- s_dout  out  DATA_WIDTH  registered read data.
- s_valid  out  1  high for exactly one cycle when s_dout holds a read result.
- init_req  in  1  starts a clear sweep when sampled high in IDLE.
- init_busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset (rst=1 at a clock edge):
  - s_dout=0, s_valid=0, init_busy=1.
  - Sweep pointer = 0; FSM enters CLEAR.
  - rst has priority over every other input.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes INIT_VALUE to mem[ptr], then ptr++. After writing ptr=DEPTH-1, FSM goes to IDLE and init_busy=0 on the next cycle.
  - A sweep takes exactly DEPTH cycles, counted from the first edge after rst deasserts.
  - In CLEAR, cen/wen/init_req are ignored; s_dout=0, s_valid=0.
  - IDLE with init_req=1: go to CLEAR with ptr=0, init_busy=1 from the next cycle. No user access is performed that cycle.
  - rst asserted mid-sweep restarts the sweep at ptr 0.
- User write (IDLE, cen=1, wen=1, init_req=0):
  - For each i with s_wbe[i]=1, mem[s_addr] byte i takes s_din byte i; other bytes are kept.
  - s_wbe = 0 performs no write.
  - s_dout per RDW_MODE:
    - mode 0: 0.
    - mode 1: merged word.
    - mode 2: pre-write word.
  - s_valid=1 next cycle in modes 1 and 2; s_valid=0 in mode 0.
- User read (IDLE, cen=1, wen=0, init_req=0): s_dout=mem[s_addr] and s_valid=1 on the next edge; latency is 1 cycle.
- cen=0 in IDLE: s_dout=0, s_valid=0 next edge; memory unchanged.
- Out-of-range address (s_addr >= DEPTH):
  - Writes are dropped.
  - Reads return s_dout=0 with s_valid=1.
- Back-to-back accesses are accepted every cycle with no bubbles.
- A read at address A on the cycle after a write to A returns the written (merged) data.
- Contents are undefined only before the first sweep completes; the bench must not read before init_busy=0.

Test Plan:
- Reset, then idle with cen=0 -> init_busy=1 for exactly 256 cycles, then 0; reads of addr 0, 128, 255 return 0 with s_valid=1 one cycle after each request.
- Write addr 5 = 64'h1122334455667788 with s_wbe=8'hFF, then write s_din=64'hAAAAAAAAAAAAAAAA with s_wbe=8'h0F, then read addr 5 -> 64'h11223344AAAAAAAA.
- RDW_MODE=0/1/2, addr 7 holding 64'h1, write 64'h2 with full enables -> s_dout = 0 / 64'h2 / 64'h1 next cycle; s_valid = 0 / 1 / 1.
- DEPTH=200, ADDR_WIDTH=8: write addr 210 = 64'hFF, read addr 210 -> s_dout=0, s_valid=1; sweep lasts 200 cycles.
- Fill addr 10 with 64'hDEAD, pulse init_req (with cen=1 on the same cycle, no access performed); 10 cycles into the sweep assert rst for 1 cycle -> sweep restarts and init_busy stays high for a full DEPTH cycles after rst drops; then read addr 10 -> INIT_VALUE.
- Back-to-back reads of addr 1, 2, 3 with cen held high -> s_dout = mem[1], mem[2], mem[3] on three consecutive cycles, s_valid held high for 3 cycles.
